// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - ALU result capture FIFO with status flags and drop counter
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    res,
    input  logic          carry,
    input  logic [3:0]    ALU_Sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_res,
    output logic          out_carry,
    output logic          out_zero,
    output logic          out_neg,
    output logic [3:0]    out_op,
    output logic          out_op_err,
    output logic [CW-1:0] count,
    output logic [7:0]    drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] op;
        logic       carry_f;
        logic       zero_f;
        logic       neg_f;
        logic       op_err;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        in_entry;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Handshake status comes only from registered occupancy, so a pop never frees a slot in the same cycle
    always_comb begin
        in_ready  = (count != CW'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Flags are frozen at capture time; carry is only meaningful for the add opcode
    always_comb begin
        in_entry.res     = res;
        in_entry.op      = ALU_Sel;
        in_entry.carry_f = (ALU_Sel == 4'b0000) ? carry : 1'b0;
        in_entry.zero_f  = (res == 8'h00);
        in_entry.neg_f   = res[7];
        in_entry.op_err  = (ALU_Sel >= 4'b1010);
    end

    // Storage array, deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers, occupancy and the saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // First-word fall-through view of the head, zeroed while empty
    always_comb begin
        head       = mem[rd_ptr];
        out_res    = out_valid ? head.res     : 8'h00;
        out_op     = out_valid ? head.op      : 4'h0;
        out_carry  = out_valid ? head.carry_f : 1'b0;
        out_zero   = out_valid ? head.zero_f  : 1'b0;
        out_neg    = out_valid ? head.neg_f   : 1'b0;
        out_op_err = out_valid ? head.op_err  : 1'b0;
    end

    // Handshake inputs must never be unknown outside reset
    a_in_valid_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(in_valid));
    a_out_ready_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(out_ready));

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    res;
    logic          carry;
    logic [3:0]    ALU_Sel;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_res;
    logic          out_carry;
    logic          out_zero;
    logic          out_neg;
    logic [3:0]    out_op;
    logic          out_op_err;
    logic [CW-1:0] count;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    alu_result_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .res(res), .carry(carry), .ALU_Sel(ALU_Sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_carry(out_carry), .out_zero(out_zero),
        .out_neg(out_neg), .out_op(out_op), .out_op_err(out_op_err),
        .count(count), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic       iv;
        logic [7:0] res;
        logic       c;
        logic [3:0] sel;
        logic       ordy;
        logic       e_valid;
        logic [7:0] e_res;
        logic       e_carry;
        logic       e_zero;
        logic       e_neg;
        logic [3:0] e_op;
        logic       e_err;
        logic [2:0] e_count;
        logic [7:0] e_drop;
        logic       e_ready;
    } vec_t;

    typedef struct packed {
        logic [7:0] r;
        logic [3:0] op;
        logic       c;
        logic       z;
        logic       n;
        logic       e;
    } ent_t;

    ent_t mq[$];
    int   mdrop;
    int   n_cmp;
    int   n_err;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; the queue model follows the spec rules
    task automatic cycle(input logic iv, input logic [7:0] r, input logic c,
                         input logic [3:0] sel, input logic ordy);
        bit   do_push, do_pop, do_drop;
        ent_t e;
        in_valid  = iv;
        res       = r;
        carry     = c;
        ALU_Sel   = sel;
        out_ready = ordy;
        do_push = iv && (mq.size() < DEPTH);
        do_drop = iv && (mq.size() == DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        e.r  = r;
        e.op = sel;
        e.c  = (sel == 4'd0) ? c : 1'b0;
        e.z  = (r == 0);
        e.n  = (r >= 8'd128);
        e.e  = (sel >= 4'd10);
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
        if (do_drop && mdrop < 255) mdrop++;
    endtask

    task automatic do_reset(input logic iv, input logic ordy);
        rst       = 1'b1;
        in_valid  = iv;
        out_ready = ordy;
        res       = 8'h5A;
        ALU_Sel   = 4'h3;
        carry     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mdrop = 0;
    endtask

    task automatic check_model(input string tag);
        ent_t h;
        bit   v;
        v = (mq.size() > 0);
        h = v ? mq[0] : '0;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
        chk({tag, " count"}, 32'(count), 32'(mq.size()));
        chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(mdrop));
        chk({tag, " out_res"}, 32'(out_res), 32'(h.r));
        chk({tag, " out_op"}, 32'(out_op), 32'(h.op));
        chk({tag, " out_flags"}, {28'd0, out_carry, out_zero, out_neg, out_op_err},
            {28'd0, h.c, h.z, h.n, h.e});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mdrop = 0;
        // iv res c sel ordy | valid res carry zero neg op err count drop ready
        tbl[0]  = '{1'b1, 8'h00, 1'b1, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 3'd1, 8'd0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 8'd0, 1'b1};
        tbl[2]  = '{1'b1, 8'h80, 1'b1, 4'h1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 3'd1, 8'd0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 8'd0, 1'b1};
        tbl[4]  = '{1'b1, 8'h00, 1'b1, 4'hC, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'hC, 1'b1, 3'd1, 8'd0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 8'd0, 1'b1};
        tbl[6]  = '{1'b1, 8'h01, 1'b0, 4'h2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd1, 8'd0, 1'b1};
        tbl[7]  = '{1'b1, 8'h02, 1'b0, 4'h2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd2, 8'd0, 1'b1};
        tbl[8]  = '{1'b1, 8'h03, 1'b0, 4'h2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd3, 8'd0, 1'b1};
        tbl[9]  = '{1'b1, 8'h04, 1'b0, 4'h2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd4, 8'd0, 1'b0};
        tbl[10] = '{1'b1, 8'h05, 1'b0, 4'h2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd4, 8'd1, 1'b0};
        tbl[11] = '{1'b1, 8'h06, 1'b0, 4'h2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd4, 8'd2, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd3, 8'd2, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd2, 8'd2, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 3'd1, 8'd2, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 8'd2, 1'b1};

        do_reset(1'b0, 1'b0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset count", 32'(count), 32'd0);
        chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
        chk("reset out_res", 32'(out_res), 32'd0);

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].iv, tbl[i].res, tbl[i].c, tbl[i].sel, tbl[i].ordy);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d out_res", i), 32'(out_res), 32'(tbl[i].e_res));
            chk($sformatf("vec%0d flags", i), {28'd0, out_carry, out_zero, out_neg, out_op_err},
                {28'd0, tbl[i].e_carry, tbl[i].e_zero, tbl[i].e_neg, tbl[i].e_err});
            chk($sformatf("vec%0d out_op", i), 32'(out_op), 32'(tbl[i].e_op));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
        end

        // Full with simultaneous push and pop: pop only, push lands next edge
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h11 + 8'(i), 1'b0, 4'h3, 1'b0);
        chk("full count", 32'(count), 32'd4);
        cycle(1'b1, 8'h15, 1'b0, 4'h3, 1'b1);
        chk("full pop count", 32'(count), 32'd3);
        chk("full pop head", 32'(out_res), 32'h12);
        chk("full pop drop", 32'(drop_cnt), 32'd3);
        cycle(1'b1, 8'h15, 1'b0, 4'h3, 1'b0);
        chk("refill count", 32'(count), 32'd4);
        check_model("refill");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d head", i), 32'(out_res), 32'(8'h12 + 8'(i)));
            cycle(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        end
        check_model("drained");

        // Steady-state streaming at count 2 across pointer wrap
        cycle(1'b1, 8'h20, 1'b0, 4'h4, 1'b0);
        cycle(1'b1, 8'h21, 1'b0, 4'h4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'h22 + 8'(i), 1'b0, 4'h4, 1'b1);
            chk($sformatf("stream%0d count", i), 32'(count), 32'd2);
            chk($sformatf("stream%0d head", i), 32'(out_res), 32'(8'h21 + 8'(i)));
        end

        // Reset mid-operation with count 3 and nonzero drop count
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 4'h5, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        chk("pre-reset count", 32'(count), 32'd3);
        do_reset(1'b1, 1'b1);
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_res", 32'(out_res), 32'd0);
        chk("midrst drop_cnt", 32'(drop_cnt), 32'd0);

        // Drop counter saturation
        for (int i = 0; i < 264; i++) cycle(1'b1, 8'(i), 1'b0, 4'h6, 1'b0);
        chk("drop saturate", 32'(drop_cnt), 32'hFF);
        check_model("saturated");
        do_reset(1'b0, 1'b0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1'($urandom), 1'($urandom));
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                      4'($urandom), 1'($urandom_range(0, 2) == 0));
            end
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 8-bit combinational ALU: captures each ALU result (res, carry, opcode) on a valid/ready handshake and derives status flags.
- Buffers results in a small synchronous FIFO so the consumer (writeback/register-file stage) can stall without losing ALU outputs.
- Reports occupancy and a saturating count of rejected pushes.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CW, 3, width of count output; must equal clog2(DEPTH+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  buffer can accept; equals !full.
- res  input  8  ALU result.
- carry  input  1  ALU carry-out (meaningful only for op 4'b0000).
- ALU_Sel  input  4  opcode that produced res.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer takes head entry.
- out_res  output  8  head result.
- out_carry  output  1  head carry flag.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result bit 7.
- out_op  output  4  head opcode.
- out_op_err  output  1  head opcode was undefined (>= 4'b1010).
- count  output  CW  entries held, 0..DEPTH.
- drop_cnt  output  8  saturating count of cycles with in_valid=1 and in_ready=0.

Behaviour:
- Synchronous active-high reset: on a clock edge with rst=1, clear write/read pointers, count=0, drop_cnt=0. Out of reset: out_valid=0, in_ready=1, and all out_* data = 0. Storage array is not reset.
- Push: occurs on an edge where in_valid && in_ready. Stores res, ALU_Sel, and the computed flags:
  - carry_f = carry when ALU_Sel==4'b0000, else 0.
  - zero_f = (res==8'h00).
  - neg_f = res[7].
  - op_err = (ALU_Sel >= 4'b1010).
- Flags are computed at push time and are not recomputed later.
- Pop: occurs on an edge where out_valid && out_ready.
- First-word fall-through. out_* reflect the head entry combinationally from storage whenever out_valid=1. All out_* data are forced to 0 when out_valid=0.
- Latency: a push into an empty buffer at edge k makes out_valid=1 in the cycle after edge k. No same-cycle bypass from input to output.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready. When full, a simultaneous pop does not enable a push in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both happen and count is unchanged.
- Empty: pop is impossible because out_valid=0; out_ready is ignored.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count is a separate register: +1 on push only, -1 on pop only.
- drop_cnt: increments on each edge with in_valid && !in_ready; saturates at 8'hFF; cleared only by rst.
- Input data while in_valid=0 is don't-care and must not affect state.
- Reset mid-operation: all buffered entries are discarded. On the next cycle out_valid=0 and count=0, regardless of in_valid or out_ready on the reset edge.
- Behaviour for any X on in_valid or out_ready is undefined. Assertions flag it.

Test Plan:
- Reset then single push (res=8'h00, carry=1, ALU_Sel=4'b0000), out_ready=0 -> next cycle out_valid=1, out_res=00, out_carry=1, out_zero=1, out_neg=0, count=1.
- Push res=8'h80, carry=1, ALU_Sel=4'b0001 -> out_carry=0 (non-add op), out_neg=1, out_zero=0, out_op_err=0.
- Push ALU_Sel=4'b1100, res=00 -> out_op_err=1, out_zero=1.
- out_ready=0, push 6 consecutive results 01..06 with DEPTH=4 -> in_ready=0 after the 4th push, count=4, drop_cnt=2. Then drain with out_ready=1 -> outputs 01,02,03,04 in order, then out_valid=0, count=0.
- Hold full with in_valid=1 and out_ready=1 -> one entry pops, no push that cycle (count 4 to 3). Push accepted on the following edge (count back to 4).
- Continuous push and pop for 10 cycles with count held at 2 -> count stays 2 and data order is preserved across pointer wrap.
- Assert rst for one cycle while count=3 and in_valid=1 -> next cycle count=0, out_valid=0, out_res=00, drop_cnt=0.
